// File: rtl/lock_key_loader_if.sv
// Serial key-load handshake between the test/secure-boot port and the key loader.
interface lock_key_loader_if;
    logic key_in_valid;
    logic key_in_bit;
    logic key_in_ready;
    logic key_abort;
    logic key_zeroize;

    modport master (
        output key_in_valid,
        output key_in_bit,
        output key_abort,
        output key_zeroize,
        input  key_in_ready
    );

    modport slave (
        input  key_in_valid,
        input  key_in_bit,
        input  key_abort,
        input  key_zeroize,
        output key_in_ready
    );
endinterface

// File: rtl/lock_key_loader.sv
// Key manager for logic-locked netlists. Keys arrive MSB first over a serial
// port into a shadow register and are committed to the active XOR/mux key
// outputs only once complete. Commits per reset are bounded; after the last
// allowed commit the block locks out until reset.
module lock_key_loader #(
    parameter int unsigned NUM_XOR   = 6,
    parameter int unsigned NUM_MUX   = 1,
    parameter int unsigned MAX_LOADS = 3,
    localparam int unsigned KW = NUM_XOR + 4 * NUM_MUX,
    localparam int unsigned CW = $clog2(MAX_LOADS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    lock_key_loader_if.slave       kif,
    output logic [NUM_XOR-1:0]     x_key,
    output logic [4*NUM_MUX-1:0]   p_key,
    output logic                   key_active,
    output logic                   locked_out,
    output logic [CW-1:0]          loads_left
);

    localparam int unsigned CNTW = (KW > 1) ? $clog2(KW) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_LOCKOUT = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [KW-1:0]   key_q, key_d;
    logic            active_q, active_d;
    logic [CW-1:0]   loads_q, loads_d;

    logic            accept;
    logic            last_bit;
    logic            shadow_clr;
    logic            shadow_shift;
    logic [KW-1:0]   shifted;

    // Ready is a pure state decode, forced low while reset is held
    always_comb begin
        kif.key_in_ready = ~rst & (state_q != ST_LOCKOUT);
    end

    assign accept   = kif.key_in_valid & kif.key_in_ready;
    assign last_bit = (cnt_q == CNTW'(KW - 1));

    // Shadow register holds the KW-1 bits preceding the final one; the final
    // bit goes straight into the active key, so a one-bit key needs no shadow.
    if (KW > 1) begin : g_shadow
        logic [KW-2:0] shadow_q, shadow_d;

        assign shifted = {shadow_q, kif.key_in_bit};

        // Next shadow value: clear, shift in accepted bit, or hold
        always_comb begin
            shadow_d = shadow_q;
            if (shadow_clr) begin
                shadow_d = '0;
            end else if (shadow_shift) begin
                shadow_d = shifted[KW-2:0];
            end
        end

        // Shadow register update
        always_ff @(posedge clk) begin
            if (rst) begin
                shadow_q <= '0;
            end else begin
                shadow_q <= shadow_d;
            end
        end
    end else begin : g_no_shadow
        logic unused_shadow_ctl;
        assign unused_shadow_ctl = shadow_clr | shadow_shift;
        assign shifted = kif.key_in_bit;
    end

    // Control: priority zeroize > abort > accepted bit
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        key_d        = key_q;
        active_d     = active_q;
        loads_d      = loads_q;
        shadow_clr   = 1'b0;
        shadow_shift = 1'b0;

        if (kif.key_zeroize) begin
            key_d      = '0;
            active_d   = 1'b0;
            cnt_d      = '0;
            shadow_clr = 1'b1;
            state_d    = (state_q == ST_LOCKOUT) ? ST_LOCKOUT : ST_IDLE;
        end else if (kif.key_abort && (state_q != ST_LOCKOUT)) begin
            cnt_d      = '0;
            shadow_clr = 1'b1;
            state_d    = ST_IDLE;
        end else if (accept) begin
            if (last_bit) begin
                key_d      = shifted;
                active_d   = 1'b1;
                cnt_d      = '0;
                shadow_clr = 1'b1;
                if (loads_q != '0) begin
                    loads_d = loads_q - CW'(1);
                end
                state_d = (loads_q <= CW'(1)) ? ST_LOCKOUT : ST_IDLE;
            end else begin
                cnt_d        = cnt_q + CNTW'(1);
                shadow_shift = 1'b1;
                state_d      = ST_LOAD;
            end
        end
    end

    // State, counter and active key registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            key_q    <= '0;
            active_q <= 1'b0;
            loads_q  <= CW'(MAX_LOADS);
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            key_q    <= key_d;
            active_q <= active_d;
            loads_q  <= loads_d;
        end
    end

    assign {p_key, x_key} = key_q;
    assign key_active     = active_q;
    assign locked_out     = (state_q == ST_LOCKOUT);
    assign loads_left     = loads_q;

endmodule

// File: tb/tb_lock_key_loader.sv
// Directed bench for lock_key_loader at default parameters (KW = 10, 3 loads).
module tb_lock_key_loader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lock_key_loader_if kif();

    logic [5:0] x_key;
    logic [3:0] p_key;
    logic       key_active;
    logic       locked_out;
    logic [1:0] loads_left;

    int n_checks = 0;
    int n_errors = 0;

    lock_key_loader dut (
        .clk        (clk),
        .rst        (rst),
        .kif        (kif),
        .x_key      (x_key),
        .p_key      (p_key),
        .key_active (key_active),
        .locked_out (locked_out),
        .loads_left (loads_left)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        kif.key_in_valid = 1'b1;
        kif.key_in_bit   = b;
        tick();
        kif.key_in_valid = 1'b0;
    endtask

    // Shift the first nbits of k (MSB first), with up to max_gap idle cycles before each bit
    task automatic shift_bits(input logic [9:0] k, input int nbits, input int max_gap);
        logic [9:0] kk;
        kk = k;
        for (int i = 0; i < nbits; i++) begin
            if (max_gap > 0) begin
                repeat ($urandom_range(max_gap, 0)) begin
                    kif.key_in_valid = 1'b0;
                    kif.key_in_bit   = 1'($urandom);
                    tick();
                end
            end
            send_bit(kk[9-i]);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_k"},      {p_key, x_key}, 32'h0);
        check({tag, "_active"}, key_active,     32'h0);
        check({tag, "_locked"}, locked_out,     32'h0);
        check({tag, "_loads"},  loads_left,     32'd3);
        check({tag, "_ready"},  kif.key_in_ready, 32'h1);
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        kif.key_in_valid = 1'b0;
        kif.key_in_bit   = 1'b0;
        kif.key_abort    = 1'b0;
        kif.key_zeroize  = 1'b0;
        tick();
        check("rst_ready_low", kif.key_in_ready, 32'h0);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        logic [9:0] pat;

        // Reset values
        do_reset();
        check_reset_state("reset");

        // First load: 1011001110, partial key never visible
        pat = 10'b1011001110;
        for (int i = 0; i < 10; i++) begin
            send_bit(pat[9-i]);
            if (i < 9) begin
                check("partial_hidden", {key_active, p_key, x_key}, 32'h0);
            end
        end
        check("load1_p",      p_key,      32'hB);
        check("load1_x",      x_key,      32'h0E);
        check("load1_active", key_active, 32'h1);
        check("load1_loads",  loads_left, 32'd2);

        // Abort after 6 bits, then a clean 0x3FF load
        do_reset();
        shift_bits(10'h000, 6, 0);
        kif.key_abort = 1'b1;
        tick();
        kif.key_abort = 1'b0;
        check("abort_k",     {p_key, x_key}, 32'h0);
        check("abort_loads", loads_left,     32'd3);
        shift_bits(10'h3FF, 10, 0);
        check("post_abort_k",     {p_key, x_key}, 32'h3FF);
        check("post_abort_loads", loads_left,     32'd2);

        // Two more commits reach lockout
        shift_bits(10'h155, 10, 0);
        check("load2_k",      {p_key, x_key}, 32'h155);
        check("load2_loads",  loads_left,     32'd1);
        check("load2_locked", locked_out,     32'h0);
        shift_bits(10'h2A6, 10, 0);
        check("load3_k",      {p_key, x_key}, 32'h2A6);
        check("load3_loads",  loads_left,     32'd0);
        check("load3_locked", locked_out,     32'h1);
        check("load3_ready",  kif.key_in_ready, 32'h0);

        // Burst while locked out changes nothing
        shift_bits(10'h0F0, 10, 0);
        check("lock_burst_k",      {p_key, x_key}, 32'h2A6);
        check("lock_burst_loads",  loads_left,     32'd0);
        check("lock_burst_locked", locked_out,     32'h1);
        check("lock_burst_active", key_active,     32'h1);

        // Zeroize in lockout clears the key but stays locked
        kif.key_zeroize = 1'b1;
        tick();
        kif.key_zeroize = 1'b0;
        check("lock_zero_k",      {p_key, x_key}, 32'h0);
        check("lock_zero_active", key_active,     32'h0);
        check("lock_zero_locked", locked_out,     32'h1);
        check("lock_zero_loads",  loads_left,     32'd0);
        check("lock_zero_ready",  kif.key_in_ready, 32'h0);

        // Zeroize coinciding with the final bit: no commit, no decrement
        do_reset();
        shift_bits(10'h123, 10, 0);
        check("pre_zero_k",     {p_key, x_key}, 32'h123);
        check("pre_zero_loads", loads_left,     32'd2);
        shift_bits(10'h3C3, 9, 0);
        kif.key_in_valid = 1'b1;
        kif.key_in_bit   = 1'b1;
        kif.key_zeroize  = 1'b1;
        tick();
        kif.key_in_valid = 1'b0;
        kif.key_zeroize  = 1'b0;
        check("zero_final_k",      {p_key, x_key}, 32'h0);
        check("zero_final_active", key_active,     32'h0);
        check("zero_final_loads",  loads_left,     32'd2);
        shift_bits(10'h0F0, 10, 0);
        check("after_zero_k",     {p_key, x_key}, 32'h0F0);
        check("after_zero_loads", loads_left,     32'd1);

        // Abort coinciding with the final bit: no commit
        shift_bits(10'h3C3, 9, 0);
        kif.key_in_valid = 1'b1;
        kif.key_in_bit   = 1'b1;
        kif.key_abort    = 1'b1;
        tick();
        kif.key_in_valid = 1'b0;
        kif.key_abort    = 1'b0;
        check("abort_final_k",     {p_key, x_key}, 32'h0F0);
        check("abort_final_loads", loads_left,     32'd1);
        check("abort_final_ready", kif.key_in_ready, 32'h1);

        // Reset in the middle of a load, then a fresh load
        do_reset();
        shift_bits(10'h155, 10, 0);
        shift_bits(10'h3FF, 5, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_reset_state("midrst");
        shift_bits(10'h2C5, 10, 0);
        check("midrst_load_k",     {p_key, x_key}, 32'h2C5);
        check("midrst_load_loads", loads_left,     32'd2);

        // Load with random gaps in valid
        shift_bits(10'h1B7, 10, 3);
        check("gap_k",      {p_key, x_key}, 32'h1B7);
        check("gap_loads",  loads_left,     32'd1);
        check("gap_active", key_active,     32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lock_key_loader.md
# lock_key_loader

Parametrised key-management block for the logic-locked benchmark netlists. It drives the XOR key inputs (`X_*`) and the 4:1 mux key inputs (`p*`) of a locked combinational core from a serially loaded, double-buffered key register. It bounds the number of key commits per reset to limit oracle-guided key search. It sits between the test/secure-boot interface and the locked netlist and replaces hand-tied key pins.

## Interface
Parameters:
- `NUM_XOR`, default 6: number of XOR/XNOR key gates; width of `x_key`.
- `NUM_MUX`, default 1: number of 4:1 mux key gates. Each gate takes 4 key bits.
- `MAX_LOADS`, default 3: key commits allowed per reset. Must be at least 1.
- Derived `KW = NUM_XOR + 4*NUM_MUX`, the total key width.
- Derived `CW = $clog2(MAX_LOADS+1)`, the width of `loads_left`.

Ports:
- `clk`, input, 1: single clock. All state changes on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `key_in_valid`, input, 1: a serial key bit is offered this cycle.
- `key_in_bit`, input, 1: the serial key bit, MSB first.
- `key_in_ready`, output, 1: the block accepts a bit this cycle.
- `key_abort`, input, 1: discard any partially shifted key.
- `key_zeroize`, input, 1: clear both the active key and the shadow key.
- `x_key`, output, `NUM_XOR`: active XOR key bits.
- `p_key`, output, `4*NUM_MUX`: active mux key bits. Gate j uses `p_key[4j+3:4j]`, ordered p4..p1.
- `key_active`, output, 1: a committed key is currently driven.
- `locked_out`, output, 1: no further commits are allowed until reset.
- `loads_left`, output, `CW`: remaining commits.

## Operation
- Key vector `K = {p_key, x_key}` has width `KW`. The serial bit accepted k-th (k = 0 first) goes to `K[KW-1-k]`.
- The shadow shift register and bit counter `cnt` (0..KW-1) are internal. The active key registers change only on commit, zeroize or reset. A partial key is never visible on the outputs.
- A bit is accepted when `key_in_valid & key_in_ready`.
- Asserting `key_in_valid` while `key_in_ready` is low has no effect.
- States:
  - IDLE: `cnt == 0`, `key_in_ready = 1`. An accepted bit moves the block to LOAD with `cnt = 1`.
  - LOAD: `key_in_ready = 1`. Each accepted bit increments `cnt`. Accepting the bit with `cnt == KW-1` commits the key:
    - shadow plus the final bit is written to `{p_key, x_key}`;
    - `key_active` is set to 1;
    - `loads_left` is decremented;
    - `cnt` is cleared;
    - next state is LOCKOUT if the new `loads_left == 0`, otherwise IDLE.
  - LOCKOUT: `key_in_ready = 0`, `locked_out = 1`. The last committed key stays driven. Only `rst` exits this state.
- `key_abort`, in IDLE or LOAD: clears `cnt` and the shadow, returns to IDLE. Active key and `loads_left` are unchanged.
- `key_zeroize`, in any state:
  - clears `x_key`, `p_key`, `key_active`, the shadow and `cnt`;
  - `loads_left` is not restored;
  - next state is IDLE, or stays LOCKOUT if already in LOCKOUT.
- Priority when events coincide: `rst` > `key_zeroize` > `key_abort` > accepted bit.
  - Zeroize or abort in the same cycle as the final bit: no commit, no decrement, and the bit is discarded.
- `KW == 1` is legal: every accepted bit commits immediately, from IDLE.
- `loads_left` never underflows. It saturates at 0, and LOCKOUT blocks any further acceptance.

## Timing
- Reset values, one cycle after the `rst` edge:
  - `x_key = 0`, `p_key = 0`, `key_active = 0`;
  - `locked_out = 0`, `loads_left = MAX_LOADS`;
  - state IDLE, `cnt = 0`.
- `key_in_ready = 0` while `rst` is high. Otherwise it is a combinational decode of state.
- Reset mid-load discards the shadow.
- Throughput is one bit per cycle. A full key takes `KW` accepting cycles.
- Commit latency:
  - new `x_key`/`p_key`, `key_active = 1` and the decremented `loads_left` are visible in the cycle after the final bit is accepted;
  - `locked_out` and `key_in_ready = 0` are visible in that same cycle.
- Zeroize and abort take effect in the cycle after assertion. All outputs are registered except `key_in_ready`.

## Test plan
- Reset, then shift `1011001110` (KW = 10) on consecutive cycles. Required:
  - `x_key` and `p_key` hold 0 for cycles 1..10;
  - in cycle 11, `p_key = 4'b1011`, `x_key = 6'b001110`, `key_active = 1`, `loads_left = 2`.
- Shift 6 bits, assert `key_abort`, then shift 10 bits of `0x3FF`. Required: the first commit gives `K = 10'h3FF` and `loads_left = 2`.
- Complete three commits. Required:
  - after the third, `locked_out = 1`, `key_in_ready = 0`, `loads_left = 0`;
  - a fourth 10-bit burst with `key_in_valid` high changes nothing;
  - the last key stays driven.
- With a committed key, assert `key_zeroize` together with the final bit of the next load. Required:
  - next cycle `x_key = 0`, `p_key = 0`, `key_active = 0`;
  - `loads_left` is unchanged, because no commit occurred.
- Assert `rst` after 5 bits of a load. Required:
  - next cycle all outputs at their reset values and `loads_left = 3`;
  - a fresh 10-bit load then commits correctly.
- Insert random gaps in `key_in_valid` during a load. Required: the committed `K` matches the bits in accepted order, with no bit lost or duplicated.
